// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, requester id width
// and the response-slot state type.
package alu_pkg;

    localparam int AND   = 0;
    localparam int OR    = 1;
    localparam int NAND  = 2;
    localparam int NOR   = 3;
    localparam int ADDU  = 4;
    localparam int SUBU  = 5;
    localparam int SLT   = 6;
    localparam int EQUAL = 7;
    localparam int SRA   = 8;
    localparam int SRAV  = 9;
    localparam int LUI   = 10;
    localparam int SLTU  = 11;

    localparam int REQ_ID_W = 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, and on a tie the
// requester that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// capturing each result into a single registered response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_n,

    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [WIDTH-1:0]    req0_src1_i,
    input  logic [WIDTH-1:0]    req0_src2_i,
    input  logic [CTRL_W-1:0]   req0_ctrl_i,

    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [WIDTH-1:0]    req1_src1_i,
    input  logic [WIDTH-1:0]    req1_src2_i,
    input  logic [CTRL_W-1:0]   req1_ctrl_i,

    output logic                alu_rst_n_o,
    output logic [WIDTH-1:0]    alu_src1_o,
    output logic [WIDTH-1:0]    alu_src2_o,
    output logic [CTRL_W-1:0]   alu_ctrl_o,
    input  logic [WIDTH-1:0]    alu_result_i,
    input  logic                alu_zero_i,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [REQ_ID_W-1:0] rsp_id_o,
    output logic [WIDTH-1:0]    rsp_result_o,
    output logic                rsp_zero_o
);

    slot_state_t         state;
    slot_state_t         state_next;
    logic                last_gnt;
    logic                slot_free;
    logic                arb_en;
    logic [1:0]          gnt;
    logic                any_gnt;
    logic [REQ_ID_W-1:0] gnt_id;

    // A full slot being drained this cycle can be refilled on the same edge.
    assign slot_free = (state == SLOT_EMPTY) || ((state == SLOT_FULL) && rsp_ready_i);
    assign arb_en    = slot_free && rst_n;
    assign any_gnt   = |gnt;
    assign gnt_id    = REQ_ID_W'(gnt[1]);

    rr_arb2 u_rr_arb2 (
        .req  ({req1_valid_i, req0_valid_i}),
        .en   (arb_en),
        .last (last_gnt),
        .gnt  (gnt)
    );

    assign req0_ready_o = gnt[0];
    assign req1_ready_o = gnt[1];
    assign alu_rst_n_o  = rst_n;

    always_comb begin
        alu_src1_o = '0;
        alu_src2_o = '0;
        alu_ctrl_o = CTRL_W'(AND);
        if (gnt[1]) begin
            alu_src1_o = req1_src1_i;
            alu_src2_o = req1_src2_i;
            alu_ctrl_o = req1_ctrl_i;
        end else if (gnt[0]) begin
            alu_src1_o = req0_src1_i;
            alu_src2_o = req0_src2_i;
            alu_ctrl_o = req0_ctrl_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (any_gnt) state_next = SLOT_FULL;
            SLOT_FULL: begin
                if (any_gnt) begin
                    state_next = SLOT_FULL;
                end else if (rsp_ready_i) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid_o = (state == SLOT_FULL);
    end

    // Last-grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            last_gnt     <= 1'b1;
        end else if (any_gnt) begin
            rsp_id_o     <= gnt_id;
            rsp_result_o <= alu_result_i;
            rsp_zero_o   <= alu_zero_i;
            last_gnt     <= gnt[1];
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a
// transaction-level reference model of the arbitration and response slot.
module tb_alu_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              req0_valid_i, req1_valid_i;
    logic              req0_ready_o, req1_ready_o;
    logic [WIDTH-1:0]  req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
    logic [CTRL_W-1:0] req0_ctrl_i, req1_ctrl_i;
    logic              alu_rst_n_o;
    logic [WIDTH-1:0]  alu_src1_o, alu_src2_o, alu_result_i;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic              alu_zero_i;
    logic              rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o;
    logic [WIDTH-1:0]  rsp_result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i), .req0_ctrl_i(req0_ctrl_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i), .req1_ctrl_i(req1_ctrl_i),
        .alu_rst_n_o(alu_rst_n_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_ctrl_o(alu_ctrl_o), .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o)
    );

    // Behavioural ALU: returns {zero, result}.
    function automatic logic [WIDTH:0] alu_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [CTRL_W-1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = ~(a & b);
            4'd3:  r = ~(a | b);
            4'd4:  r = a + b;
            4'd5:  r = a - b;
            4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  r = (a == b) ? 32'd1 : 32'd0;
            4'd8:  r = $unsigned($signed(b) >>> a[4:0]);
            4'd9:  r = $unsigned($signed(b) >>> a[4:0]);
            4'd10: r = {b[15:0], 16'h0000};
            4'd11: r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {(r == '0), r};
    endfunction

    assign {alu_zero_i, alu_result_i} = alu_model(alu_src1_o, alu_src2_o, alu_ctrl_o);

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_reqs();
        req0_valid_i = 0; req1_valid_i = 0;
        req0_src1_i = '0; req0_src2_i = '0; req0_ctrl_i = '0;
        req1_src1_i = '0; req1_src2_i = '0; req1_ctrl_i = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; rsp_ready_i = 1;
        clear_reqs();
        req0_valid_i = 1; req1_valid_i = 1;
        step();
        step();
        checks++;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", rsp_valid_o); end
        checks++;
        if ({rsp_id_o, rsp_zero_o, rsp_result_o} !== 34'd0) begin
            errors++; $display("[TB] FAIL reset_data: got id=%b zero=%b result=%h want all 0", rsp_id_o, rsp_zero_o, rsp_result_o);
        end
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ready: got %b%b want 00", req0_ready_o, req1_ready_o);
        end
        checks++;
        if (alu_rst_n_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_alu_rst_n: got %b want 0", alu_rst_n_o); end
        clear_reqs();
        rst_n = 1;
        #1;
        checks++;
        if (alu_rst_n_o !== 1'b1) begin errors++; $display("[TB] FAIL release_alu_rst_n: got %b want 1", alu_rst_n_o); end
        checks++;
        if ({alu_src1_o, alu_src2_o, alu_ctrl_o} !== '0) begin
            errors++; $display("[TB] FAIL idle_alu_inputs: got %h %h %h want 0 0 0", alu_src1_o, alu_src2_o, alu_ctrl_o);
        end
    endtask

    task automatic test_single_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  input logic [31:0] exp_res, input logic exp_zero);
        req0_valid_i = 1; req0_src1_i = a; req0_src2_i = b; req0_ctrl_i = op;
        rsp_ready_i = 1;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++; $display("[TB] FAIL single_ready: got %b%b want 10", req0_ready_o, req1_ready_o);
        end
        step();
        clear_reqs();
        checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_result_o} !== {1'b1, 1'b0, exp_zero, exp_res}) begin
            errors++;
            $display("[TB] FAIL single_rsp: got valid=%b id=%b zero=%b result=%h want 1 0 %b %h",
                     rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_result_o, exp_zero, exp_res);
        end
        step();
        checks++;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got %b want 0", rsp_valid_o); end
    endtask

    task automatic test_tie_after_reset();
        rst_n = 0; step(); rst_n = 1;
        req0_valid_i = 1; req0_src1_i = 32'hF0; req0_src2_i = 32'h3C; req0_ctrl_i = 4'd0;
        req1_valid_i = 1; req1_src1_i = 32'hF0; req1_src2_i = 32'h0F; req1_ctrl_i = 4'd1;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++; $display("[TB] FAIL tie_first_ready: got %b%b want 10", req0_ready_o, req1_ready_o);
        end
        step();
        req0_valid_i = 0;
        checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {1'b1, 1'b0, 32'h30}) begin
            errors++; $display("[TB] FAIL tie_first_rsp: got %b %b %h want 1 0 00000030", rsp_valid_o, rsp_id_o, rsp_result_o);
        end
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
            errors++; $display("[TB] FAIL tie_second_ready: got %b%b want 01", req0_ready_o, req1_ready_o);
        end
        step();
        req1_valid_i = 0;
        checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {1'b1, 1'b1, 32'hFF}) begin
            errors++; $display("[TB] FAIL tie_second_rsp: got %b %b %h want 1 1 000000ff", rsp_valid_o, rsp_id_o, rsp_result_o);
        end
    endtask

    // Both requesters always have work; grants must alternate starting with 0.
    task automatic test_back_to_back();
        logic [31:0] want;
        rsp_ready_i = 1;
        req0_valid_i = 1; req0_ctrl_i = 4'd4; req0_src1_i = $urandom; req0_src2_i = $urandom;
        req1_valid_i = 1; req1_ctrl_i = 4'd4; req1_src1_i = $urandom; req1_src2_i = $urandom;
        for (int i = 0; i < 6; i++) begin
            #1;
            want = (i % 2 == 0) ? req0_src1_i + req0_src2_i : req1_src1_i + req1_src2_i;
            step();
            checks++;
            if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {1'b1, 1'(i % 2), want}) begin
                errors++; $display("[TB] FAIL b2b_rsp[%0d]: got %b %b %h want 1 %0d %h", i, rsp_valid_o, rsp_id_o, rsp_result_o, i % 2, want);
            end
            if (i % 2 == 0) begin req0_src1_i = $urandom; req0_src2_i = $urandom; end
            else            begin req1_src1_i = $urandom; req1_src2_i = $urandom; end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_res;
        logic        held_id;
        logic [31:0] want;
        held_res = rsp_result_o;
        held_id  = rsp_id_o;
        rsp_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
                errors++; $display("[TB] FAIL bp_ready[%0d]: got %b%b want 00", i, req0_ready_o, req1_ready_o);
            end
            step();
            checks++;
            if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {1'b1, held_id, held_res}) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got %b %b %h want 1 %b %h", i, rsp_valid_o, rsp_id_o, rsp_result_o, held_id, held_res);
            end
        end
        rsp_ready_i = 1;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++; $display("[TB] FAIL bp_release_ready: got %b%b want 10", req0_ready_o, req1_ready_o);
        end
        want = req0_src1_i + req0_src2_i;
        step();
        checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {1'b1, 1'b0, want}) begin
            errors++; $display("[TB] FAIL bp_refill: got %b %b %h want 1 0 %h", rsp_valid_o, rsp_id_o, rsp_result_o, want);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 0;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            errors++; $display("[TB] FAIL midrst_ready: got %b%b want 00", req0_ready_o, req1_ready_o);
        end
        step();
        checks++;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b want 0", rsp_valid_o); end
        rst_n = 1;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++; $display("[TB] FAIL midrst_after_ready: got %b%b want 10", req0_ready_o, req1_ready_o);
        end
        step();
        clear_reqs();
        step();
    endtask

    // Random traffic against a transaction-level model of the slot and pointer.
    task automatic test_random();
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic [3:0]  op [2];
        bit          pend [2];
        bit          m_full, m_last, m_id, m_zero;
        logic [31:0] m_res;
        logic [32:0] zr;
        int          g;
        rst_n = 0; clear_reqs(); step(); rst_n = 1;
        m_full = 0; m_last = 1; m_id = 0; m_res = '0; m_zero = 0;
        pend[0] = 0; pend[1] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1;
                    a[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
                    b[r]  = ($urandom_range(0, 3) == 0) ? a[r] : $urandom;
                    op[r] = 4'($urandom_range(0, 11));
                end
            end
            req0_valid_i = pend[0]; req0_src1_i = a[0]; req0_src2_i = b[0]; req0_ctrl_i = op[0];
            req1_valid_i = pend[1]; req1_src1_i = a[1]; req1_src2_i = b[1]; req1_ctrl_i = op[1];
            rsp_ready_i  = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!m_full || rsp_ready_i) begin
                if (pend[0] && pend[1]) g = m_last ? 0 : 1;
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
            end
            checks++;
            if (req0_ready_o !== (g == 0) || req1_ready_o !== (g == 1)) begin
                errors++; $display("[TB] FAIL rand_ready[%0d]: got %b%b want grant=%0d", cyc, req0_ready_o, req1_ready_o, g);
            end
            if (g >= 0) begin
                checks++;
                if (alu_src1_o !== a[g] || alu_src2_o !== b[g] || alu_ctrl_o !== op[g]) begin
                    errors++; $display("[TB] FAIL rand_alu_mux[%0d]: got %h %h %h want %h %h %h", cyc, alu_src1_o, alu_src2_o, alu_ctrl_o, a[g], b[g], op[g]);
                end
            end
            step();
            if (g >= 0) begin
                zr = alu_model(a[g], b[g], op[g]);
                m_full = 1; m_id = 1'(g); m_res = zr[31:0]; m_zero = zr[32]; m_last = 1'(g);
                pend[g] = 0;
            end else if (m_full && rsp_ready_i) begin
                m_full = 0;
            end
            checks++;
            if (rsp_valid_o !== m_full || (m_full && {rsp_id_o, rsp_zero_o, rsp_result_o} !== {m_id, m_zero, m_res})) begin
                errors++;
                $display("[TB] FAIL rand_rsp[%0d]: got %b %b %b %h want %b %b %b %h", cyc, rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_result_o,
                         m_full, m_id, m_zero, m_res);
            end
        end
        clear_reqs();
    endtask

    initial begin
        test_reset();
        test_single_op(32'd5, 32'd7, 4'd4, 32'd12, 1'b0);
        test_single_op(32'd9, 32'd9, 4'd5, 32'd0, 1'b1);
        test_tie_after_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
